// File: rtl/temp_to_dig_if.sv
// rtl/temp_to_dig_if.sv - sensor-side bundle: raw comparator input and latched temperature code
interface temp_to_dig_if;
  logic       comp_out;
  logic [7:0] temp;
  logic       temp_valid;

  modport master (
    output comp_out,
    input  temp,
    input  temp_valid
  );

  modport slave (
    input  comp_out,
    output temp,
    output temp_valid
  );
endinterface

// File: rtl/temp_to_dig.sv
// rtl/temp_to_dig.sv - counts synchronized comparator rising edges per fixed window into an 8-bit code
// Optional macro TEMP_TO_DIG_AVG_EN: report the mean of the current and previous window counts.
module temp_to_dig #(
  parameter int WINDOW      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  temp_to_dig_if.slave bus
);
  localparam int WCNT_W = $clog2(WINDOW);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   edge_det;
  logic [WCNT_W-1:0]      wcnt;
  logic                   closing;
  logic [7:0]             ecnt;
  logic [7:0]             count_sat;
  logic [7:0]             temp_q;
  logic                   temp_valid_q;

  assign edge_det  = sync_q[SYNC_STAGES-1] & ~prev;
  assign closing   = (wcnt == WCNT_W'(WINDOW - 1));
  assign count_sat = (edge_det && (ecnt != 8'hff)) ? ecnt + 8'd1 : ecnt;

  // Preloading the chain with the live level keeps a level held across reset from looking like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{bus.comp_out}};
      prev   <= bus.comp_out;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.comp_out};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt <= '0;
      ecnt <= '0;
    end else if (closing) begin
      wcnt <= '0;
      ecnt <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
      ecnt <= count_sat;
    end
  end

`ifdef TEMP_TO_DIG_AVG_EN
  logic [7:0] last_q;
  logic       have_last;
  logic [8:0] avg_sum;

  assign avg_sum = {1'b0, count_sat} + {1'b0, last_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      last_q       <= '0;
      have_last    <= 1'b0;
    end else begin
      temp_valid_q <= closing;
      if (closing) begin
        temp_q    <= have_last ? avg_sum[8:1] : count_sat;
        last_q    <= count_sat;
        have_last <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
    end else begin
      temp_valid_q <= closing;
      if (closing) begin
        temp_q <= count_sat;
      end
    end
  end
`endif

  assign bus.temp       = temp_q;
  assign bus.temp_valid = temp_valid_q;
endmodule

// File: tb/tb_temp_to_dig.sv
// tb/tb_temp_to_dig.sv - randomized and directed checks of temp_to_dig against a sample-history model
module tb_temp_to_dig;
  localparam int W0 = 16;
  localparam int S0 = 2;
  localparam int W1 = 1024;
  localparam int S1 = 3;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic comp_out = 1'b0;

  always #5 clk = ~clk;

  temp_to_dig_if if0 ();
  temp_to_dig_if if1 ();
  assign if0.comp_out = comp_out;
  assign if1.comp_out = comp_out;

  temp_to_dig #(.WINDOW(W0), .SYNC_STAGES(S0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  temp_to_dig #(.WINDOW(W1), .SYNC_STAGES(S1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: raw samples since reset; a raw rise sampled at cycle k is counted at cycle k+S.
  int   n;
  logic s0;
  logic hist[int];
  int   wc[2];
  int   et[2];
  int   lastc[2];
  bit   ev[2];
  bit   hl[2];
  int   win[2] = '{W0, W1};
  int   stg[2] = '{S0, S1};
  logic cv, rv;
  int   c, k;

  function automatic logic samp(input int idx);
    return (idx <= 0) ? s0 : hist[idx];
  endfunction

  always @(posedge clk) begin
    cv = comp_out;
    rv = reset;
    #1;
    if (rv) begin
      n  = 0;
      s0 = cv;
      hist.delete();
      for (int d = 0; d < 2; d++) begin
        wc[d] = 0; et[d] = 0; lastc[d] = 0; ev[d] = 1'b0; hl[d] = 1'b0;
      end
    end else begin
      n++;
      hist[n] = cv;
      for (int d = 0; d < 2; d++) begin
        k = n - stg[d];
        if (samp(k) && !samp(k - 1)) wc[d]++;
        if (n % win[d] == 0) begin
          c = (wc[d] > 255) ? 255 : wc[d];
`ifdef TEMP_TO_DIG_AVG_EN
          et[d]    = hl[d] ? (c + lastc[d]) / 2 : c;
          lastc[d] = c;
          hl[d]    = 1'b1;
`else
          et[d] = c;
`endif
          ev[d] = 1'b1;
          wc[d] = 0;
        end else begin
          ev[d] = 1'b0;
        end
      end
    end
    chk("dut0_temp",  32'(if0.temp),       et[0]);
    chk("dut0_valid", 32'(if0.temp_valid), int'(ev[0]));
    chk("dut1_temp",  32'(if1.temp),       et[1]);
    chk("dut1_valid", 32'(if1.temp_valid), int'(ev[1]));
  end

  task automatic tick(input logic v, input logic r);
    @(negedge clk);
    comp_out = v;
    reset    = r;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  logic v;
  int   hold;

  initial begin
    // held-high level across reset release
    repeat (3) tick(1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) tick(1'b1, 1'b0);
    settle();
    chk("lvl_valid", 32'(if0.temp_valid), 1);
    chk("lvl_temp",  32'(if0.temp),       0);

    // toggle every clock: 8 per 16-cycle window, saturation on the long window
    repeat (2) tick(1'b0, 1'b1);
    for (int i = 1; i <= 1024; i++) begin
      tick((i % 2) == 1, 1'b0);
      if (i == 32) begin
        settle();
        chk("tog_valid", 32'(if0.temp_valid), 1);
`ifdef TEMP_TO_DIG_AVG_EN
        chk("tog_temp", 32'(if0.temp), 7);
`else
        chk("tog_temp", 32'(if0.temp), 8);
`endif
      end
      if (i == 1024) begin
        settle();
        chk("sat_valid", 32'(if1.temp_valid), 1);
        chk("sat_temp",  32'(if1.temp),       255);
      end
    end

    // three edges, the last one detected in the closing cycle
    repeat (2) tick(1'b0, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      tick((i == 2) || (i == 6) || (i == 14), 1'b0);
      if (i == 16) begin
        settle();
        chk("three_temp", 32'(if0.temp), 3);
      end
      if (i == 32) begin
        settle();
`ifdef TEMP_TO_DIG_AVG_EN
        chk("quiet_temp", 32'(if0.temp), 1);
`else
        chk("quiet_temp", 32'(if0.temp), 0);
`endif
      end
    end

    // reset in the middle of a window
    repeat (2) tick(1'b0, 1'b1);
    for (int i = 1; i <= 27; i++) begin
      tick((i % 2) == 1, 1'b0);
      if (i == 16) begin
        settle();
        chk("pre_rst_temp", 32'(if0.temp), 7);
      end
    end
    tick(1'b0, 1'b1);
    settle();
    chk("mid_rst_temp",  32'(if0.temp),       0);
    chk("mid_rst_valid", 32'(if0.temp_valid), 0);
    for (int i = 1; i <= 16; i++) begin
      tick(1'b0, 1'b0);
      if (i == 15) begin
        settle();
        chk("fresh_win_early", 32'(if0.temp_valid), 0);
      end
      if (i == 16) begin
        settle();
        chk("fresh_win_valid", 32'(if0.temp_valid), 1);
        chk("fresh_win_temp",  32'(if0.temp),       0);
      end
    end

    // windows of 7, 8, 8, 4 edges
    repeat (2) tick(1'b0, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      tick(((i % 2) == 1) && (i <= 53), 1'b0);
      if (i == 48) begin
        settle();
        chk("w3_temp", 32'(if0.temp), 8);
      end
      if (i == 64) begin
        settle();
`ifdef TEMP_TO_DIG_AVG_EN
        chk("w4_temp", 32'(if0.temp), 6);
`else
        chk("w4_temp", 32'(if0.temp), 4);
`endif
      end
    end

    // random hold lengths with occasional reset
    repeat (2) tick(1'b0, 1'b1);
    v    = 1'b0;
    hold = 0;
    for (int i = 0; i < 900; i++) begin
      if (hold == 0) begin
        v    = ~v;
        hold = int'($urandom_range(1, 4));
      end
      hold--;
      tick(v, $urandom_range(0, 199) == 0);
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
